// File: rtl/muldiv_unit.sv
// Sequential multiply/divide engine that owns the HI/LO registers.
// It takes 32 shift-add or restoring-divide steps, then signals a one-cycle valid pulse.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO write here in a single cycle
// S_CALC | one iteration per cycle, cnt_q counts steps 0..WIDTH-1
// S_DONE | result already committed to hi/lo; valid is high for this cycle
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       alucontrol,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, low_q, low_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic             divz_q, divz_d, busy_q, busy_d, valid_q, valid_d;

  logic             op_mul, op_div, op_sgn, op_mthi, op_mtlo, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b, step_acc, step_low;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign op_mul  = (alucontrol == 8'h18) || (alucontrol == 8'h19);
  assign op_div  = (alucontrol == 8'h1A) || (alucontrol == 8'h1B);
  assign op_sgn  = (alucontrol == 8'h18) || (alucontrol == 8'h1A);
  assign op_mthi = (alucontrol == 8'h11);
  assign op_mtlo = (alucontrol == 8'h13);

  assign sa    = op_sgn & a[WIDTH-1];
  assign sb    = op_sgn & b[WIDTH-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;

  // {acc_q, low_q} is the product/shift register: acc holds the running upper
  // half (mult) or partial remainder (div); low holds multiplier or dividend bits.
  assign mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {acc_q, low_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign step_acc = is_div_q ? (div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0])
                             : mul_sum[WIDTH:1];
  assign step_low = is_div_q ? {low_q[WIDTH-2:0], ~div_diff[WIDTH]}
                             : {mul_sum[0], low_q[WIDTH-1:1]};

  assign prod     = {step_acc, step_low};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    low_d    = low_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    divz_d   = divz_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (op_mul || op_div) begin
            state_d  = S_CALC;
            cnt_d    = '0;
            acc_d    = '0;
            is_div_d = op_div;
            neg_a_d  = sa;
            neg_b_d  = sb;
            low_d    = op_div ? abs_a : abs_b;
            opnd_d   = op_div ? abs_b : abs_a;
            divz_d   = op_div && (b == '0);
          end else if (op_mthi) begin
            hi_d = a;
          end else if (op_mtlo) begin
            lo_d = a;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step_acc;
          low_d = step_low;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_DONE;
            if (is_div_q) begin
              // Remainder follows the dividend sign; divide-by-zero forces all-ones quotient.
              lo_d = divz_q ? '1 : ((neg_a_q ^ neg_b_q) ? -step_low : step_low);
              hi_d = neg_a_q ? -step_acc : step_acc;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      low_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      divz_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      divz_q   <= divz_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
